led7_scan_driver: RTL and testbench

- Time-multiplexed driver for a P_DIGITS-wide common-anode 7-segment display.
- Scans one digit per refresh slot and decodes its 4-bit hex nibble to an active-low segment pattern.
- Drives the active-low anode of the selected digit and inserts a dead-time at each slot start to suppress ghosting.
- Sits between the top-level board wrapper and the display pins. Supports per-digit decimal point, per-digit blanking, global enable and leading-zero suppression.

---
 rtl/led7_scan_driver.sv | 131 +++++++++++++
 tb/tb_led7_scan_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: one digit per refresh slot, hex decode,
// dead-time at slot start, per-digit dp/blank, leading-zero suppression; outputs registered.
module led7_scan_driver #(
   parameter int P_DIGITS      = 8,
   parameter int P_REFRESH_DIV = 100000,
   parameter int P_DEAD        = 16
) (
   input  logic                  i_w_clk,
   input  logic                  i_w_reset,
   input  logic [4*P_DIGITS-1:0] i_w_value,
   input  logic [P_DIGITS-1:0]   i_w_dp,
   input  logic [P_DIGITS-1:0]   i_w_blank,
   input  logic                  i_w_enable,
   input  logic                  i_w_lzs,
   output logic                  o_w_ca,
   output logic                  o_w_cb,
   output logic                  o_w_cc,
   output logic                  o_w_cd,
   output logic                  o_w_ce,
   output logic                  o_w_cf,
   output logic                  o_w_cg,
   output logic                  o_w_dp,
   output logic [P_DIGITS-1:0]   o_w_an
);

   localparam int CNT_W = $clog2(P_REFRESH_DIV);
   localparam int IDX_W = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_DIGITS - 1);

   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [7:0]          r_seg;
   logic [P_DIGITS-1:0] r_an;

   logic                w_dead;
   logic                w_dark;
   logic                w_zero_run;
   logic [3:0]          w_nib;
   logic                w_dp_sel;
   logic                w_blank_sel;
   logic                w_supp_sel;
   logic [P_DIGITS-1:0] w_an_sel;

   // Active-low g..a pattern; the dp bit is inserted separately.
   function automatic logic [6:0] f_glyph(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h18;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (i_w_enable) begin
         if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   generate
      if (P_DEAD == 0) begin : g_no_dead
         assign w_dead = 1'b0;
      end else begin : g_dead
         assign w_dead = (r_cnt < CNT_W'(P_DEAD));
      end
   endgenerate

   // Walk from the most significant digit down so the zero run is known when idx is reached.
   always_comb begin
      w_zero_run  = 1'b1;
      w_nib       = 4'h0;
      w_dp_sel    = 1'b0;
      w_blank_sel = 1'b0;
      w_supp_sel  = 1'b0;
      w_an_sel    = '1;
      for (int k = P_DIGITS - 1; k >= 0; k--) begin
         w_zero_run = w_zero_run & (i_w_value[4*k +: 4] == 4'h0);
         if (r_idx == IDX_W'(k)) begin
            w_nib       = i_w_value[4*k +: 4];
            w_dp_sel    = i_w_dp[k];
            w_blank_sel = i_w_blank[k];
            w_supp_sel  = i_w_lzs & w_zero_run & (k != 0);
            w_an_sel[k] = 1'b0;
         end
      end
   end

   assign w_dark = ~i_w_enable | w_blank_sel | w_supp_sel | w_dead;

   always_ff @(posedge i_w_clk) begin
      if (i_w_reset || w_dark) begin
         r_seg <= 8'hFF;
         r_an  <= '1;
      end else begin
         r_seg <= {~w_dp_sel, f_glyph(w_nib)};
         r_an  <= w_an_sel;
      end
   end

   assign o_w_ca = r_seg[0];
   assign o_w_cb = r_seg[1];
   assign o_w_cc = r_seg[2];
   assign o_w_cd = r_seg[3];
   assign o_w_ce = r_seg[4];
   assign o_w_cf = r_seg[5];
   assign o_w_cg = r_seg[6];
   assign o_w_dp = r_seg[7];
   assign o_w_an = r_an;

endmodule

// File: tb/tb_led7_scan_driver.sv
// Bench for led7_scan_driver: a 4-digit instance (div 4, dead 1) and a 1-digit instance (dead 0)
// checked against a slot/tick model and fixed expected sequences.
module tb_led7_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        enable;
   logic        lzs;
   logic [3:0]  value1;
   logic        dp1;
   logic        blank1;

   logic ca, cb, cc, cd, ce, cf, cg, dpo;
   logic [3:0] an;
   logic ca1, cb1, cc1, cd1, ce1, cf1, cg1, dpo1;
   logic an1;
   logic [7:0] seg, seg1;

   int errors = 0;
   int checks = 0;
   int m_ticks = 0;

   always #5 clk = ~clk;

   led7_scan_driver #(.P_DIGITS(4), .P_REFRESH_DIV(4), .P_DEAD(1)) dut (
      .i_w_clk(clk), .i_w_reset(reset), .i_w_value(value), .i_w_dp(dp),
      .i_w_blank(blank), .i_w_enable(enable), .i_w_lzs(lzs),
      .o_w_ca(ca), .o_w_cb(cb), .o_w_cc(cc), .o_w_cd(cd), .o_w_ce(ce),
      .o_w_cf(cf), .o_w_cg(cg), .o_w_dp(dpo), .o_w_an(an)
   );

   led7_scan_driver #(.P_DIGITS(1), .P_REFRESH_DIV(4), .P_DEAD(0)) dut1 (
      .i_w_clk(clk), .i_w_reset(reset), .i_w_value(value1), .i_w_dp(dp1),
      .i_w_blank(blank1), .i_w_enable(enable), .i_w_lzs(lzs),
      .o_w_ca(ca1), .o_w_cb(cb1), .o_w_cc(cc1), .o_w_cd(cd1), .o_w_ce(ce1),
      .o_w_cf(cf1), .o_w_cg(cg1), .o_w_dp(dpo1), .o_w_an(an1)
   );

   assign seg  = {dpo, cg, cf, ce, cd, cc, cb, ca};
   assign seg1 = {dpo1, cg1, cf1, ce1, cd1, cc1, cb1, ca1};

   function automatic logic [7:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
         4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
         4'h8: return 8'h80;  4'h9: return 8'h98;  4'hA: return 8'h88;  4'hB: return 8'h83;
         4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   // Model: m_ticks counts enabled cycles since reset; slot position and digit follow by division.
   task automatic tick(output logic [3:0] e_an, output logic [7:0] e_seg,
                       output logic e_an1, output logic [7:0] e_seg1);
      int pos, idx;
      logic [3:0] nib;
      logic [7:0] g;
      logic dark, dark1;
      pos  = m_ticks % 4;
      idx  = (m_ticks / 4) % 4;
      nib  = 4'((value >> (4 * idx)) & 16'hF);
      g    = glyph(nib);
      dark = reset || !enable || blank[idx] || (pos < 1) ||
             (lzs && idx != 0 && (value >> (4 * idx)) == 16'h0);
      e_an  = dark ? 4'hF : ~(4'b0001 << idx);
      e_seg = dark ? 8'hFF : {~dp[idx], g[6:0]};
      g      = glyph(value1);
      dark1  = reset || !enable || blank1;
      e_an1  = dark1;
      e_seg1 = dark1 ? 8'hFF : {~dp1, g[6:0]};
      @(posedge clk);
      #1;
      if (reset) m_ticks = 0;
      else if (enable) m_ticks++;
   endtask

   task automatic test_reset();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      reset = 1'b1; value = 16'h1234; dp = 4'h0; blank = 4'h0; enable = 1'b1; lzs = 1'b0;
      value1 = 4'h0; dp1 = 1'b0; blank1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(ea, es, ea1, es1);
         checks++;
         if (an !== 4'hF || seg !== 8'hFF || an1 !== 1'b1 || seg1 !== 8'hFF) begin
            errors++;
            $display("FAIL reset cyc%0d: an=%b seg=%h an1=%b seg1=%h, expected 1111/ff/1/ff",
                     i, an, seg, an1, seg1);
         end
      end
   endtask

   task automatic test_release();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      logic [3:0] an_tbl [8] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};
      logic [7:0] sg_tbl [8] = '{8'hFF, 8'h99, 8'h99, 8'h99, 8'hFF, 8'hB0, 8'hB0, 8'hB0};
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(ea, es, ea1, es1);
         checks++;
         if (an !== an_tbl[i] || seg !== sg_tbl[i]) begin
            errors++;
            $display("FAIL release cyc%0d: an=%b seg=%h, expected an=%b seg=%h",
                     i + 1, an, seg, an_tbl[i], sg_tbl[i]);
         end
      end
   endtask

   task automatic test_full_scan();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      int lows [4] = '{0, 0, 0, 0};
      int first [4] = '{-1, -1, -1, -1};
      reset = 1'b1; value = 16'h1234;
      tick(ea, es, ea1, es1);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick(ea, es, ea1, es1);
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL scan cyc%0d: an=%b seg=%h, expected an=%b seg=%h", i, an, seg, ea, es);
         end
         for (int k = 0; k < 4; k++)
            if (an[k] === 1'b0) begin
               lows[k]++;
               if (first[k] < 0) first[k] = i;
            end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (lows[k] != 3 || (k > 0 && first[k] <= first[k-1])) begin
            errors++;
            $display("FAIL scan_count an%0d: low %0d cycles first at %0d, expected 3 cycles in order",
                     k, lows[k], first[k]);
         end
      end
      tick(ea, es, ea1, es1);
      tick(ea, es, ea1, es1);
      checks++;
      if (an !== 4'b1110) begin
         errors++;
         $display("FAIL scan_wrap: an=%b, expected 1110", an);
      end
   endtask

   task automatic test_dp_blank();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      int saw_dp1 = 0;
      int lit2 = 0;
      reset = 1'b1; value = 16'h1234; dp = 4'b0010; blank = 4'b0100;
      tick(ea, es, ea1, es1);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick(ea, es, ea1, es1);
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL dp_blank cyc%0d: an=%b seg=%h, expected an=%b seg=%h", i, an, seg, ea, es);
         end
         if (an === 4'b1101 && seg[7] === 1'b0) saw_dp1++;
         if (an === 4'b1011) lit2++;
      end
      checks++;
      if (saw_dp1 != 3 || lit2 != 0) begin
         errors++;
         $display("FAIL dp_blank_sum: dp1 cycles=%0d digit2 lit=%0d, expected 3 and 0", saw_dp1, lit2);
      end
      dp = 4'h0; blank = 4'h0;
   endtask

   task automatic test_lzs();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      logic [15:0] pats [2] = '{16'h0050, 16'h0000};
      for (int p = 0; p < 2; p++) begin
         int bad = 0;
         reset = 1'b1; value = pats[p]; lzs = 1'b1;
         tick(ea, es, ea1, es1);
         reset = 1'b0;
         for (int i = 0; i < 16; i++) begin
            tick(ea, es, ea1, es1);
            checks++;
            if (an !== ea || seg !== es) begin
               errors++;
               $display("FAIL lzs %h cyc%0d: an=%b seg=%h, expected an=%b seg=%h",
                        pats[p], i, an, seg, ea, es);
            end
            if (an === 4'b0111 || an === 4'b1011) bad++;
            if (an === 4'b1110 && seg !== 8'hC0) bad++;
            if (an === 4'b1101 && (p == 1 || seg !== 8'h92)) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL lzs_digits %h: %0d cycles with wrong digit lit, expected 0", pats[p], bad);
         end
      end
      lzs = 1'b0;
   endtask

   task automatic test_enable_freeze();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      reset = 1'b1; value = 16'h1234;
      tick(ea, es, ea1, es1);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) tick(ea, es, ea1, es1);
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(ea, es, ea1, es1);
         checks++;
         if (an !== 4'hF || seg !== 8'hFF || an1 !== 1'b1) begin
            errors++;
            $display("FAIL disabled cyc%0d: an=%b seg=%h an1=%b, expected 1111/ff/1", i, an, seg, an1);
         end
      end
      enable = 1'b1;
      tick(ea, es, ea1, es1);
      checks++;
      if (an !== 4'b1101 || seg !== 8'hB0) begin
         errors++;
         $display("FAIL resume: an=%b seg=%h, expected 1101/b0", an, seg);
      end
      for (int i = 0; i < 6; i++) begin
         tick(ea, es, ea1, es1);
         checks++;
         if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL resume cyc%0d: an=%b seg=%h, expected an=%b seg=%h", i, an, seg, ea, es);
         end
      end
   endtask

   task automatic test_single_digit();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      reset = 1'b1; value1 = 4'h7;
      tick(ea, es, ea1, es1);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(ea, es, ea1, es1);
         checks++;
         if (an1 !== 1'b0 || seg1 !== es1) begin
            errors++;
            $display("FAIL single cyc%0d: an1=%b seg1=%h, expected 0/%h", i, an1, seg1, es1);
         end
         value1 = 4'($urandom_range(0, 15));
         dp1 = 1'($urandom_range(0, 1));
      end
      dp1 = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0] ea; logic [7:0] es, es1; logic ea1;
      for (int i = 0; i < 400; i++) begin
         value  = 16'($urandom);
         if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
         dp     = 4'($urandom);
         blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         enable = ($urandom_range(0, 7) != 0);
         lzs    = 1'($urandom_range(0, 1));
         reset  = ($urandom_range(0, 49) == 0);
         value1 = 4'($urandom);
         dp1    = 1'($urandom_range(0, 1));
         blank1 = ($urandom_range(0, 5) == 0);
         tick(ea, es, ea1, es1);
         checks++;
         if (an !== ea || seg !== es || an1 !== ea1 || seg1 !== es1 || $countones(~an) > 1) begin
            errors++;
            $display("FAIL random cyc%0d: an=%b seg=%h an1=%b seg1=%h, expected an=%b seg=%h an1=%b seg1=%h",
                     i, an, seg, an1, seg1, ea, es, ea1, es1);
         end
      end
      reset = 1'b0; enable = 1'b1; blank = 4'h0; blank1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_release();
      test_full_scan();
      test_dp_blank();
      test_lzs();
      test_enable_freeze();
      test_single_digit();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
